// File: rtl/ghost_scheduler.sv
// Four-ghost movement scheduler: one pass per frame, each ghost probes the shared
// wall lookup for up to four candidate directions and steps one pixel on the first free one.
module ghost_scheduler #(
   parameter logic [8:0] HOME_X  = 9'd96,
   parameter logic [8:0] HOME_Y  = 9'd112,
   parameter logic [8:0] SPACING = 9'd16,
   parameter logic [8:0] MAX_X   = 9'd223
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       enable,
   output logic       wall_req,
   output logic [8:0] wall_x,
   output logic [8:0] wall_y,
   input  logic       wall_ack,
   input  logic       wall_hit,
   output logic [8:0] x_red,
   output logic [8:0] y_red,
   output logic [8:0] x_pink,
   output logic [8:0] y_pink,
   output logic [8:0] x_blue,
   output logic [8:0] y_blue,
   output logic [8:0] x_yellow,
   output logic [8:0] y_yellow,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StMove, StNext} state_e;

   state_e     state_q;
   logic [8:0] x_q   [4];
   logic [8:0] y_q   [4];
   logic [1:0] dir_q [4];
   logic [1:0] idx_q;
   logic [1:0] att_q;
   logic [1:0] mv_dir_q;
   logic       wall_req_q;
   logic [8:0] wall_x_q;
   logic [8:0] wall_y_q;
   logic       busy_q;
   logic       done_q;
   logic       overrun_q;

   logic [1:0] req_idx;
   logic [1:0] req_att;
   logic [1:0] req_dir;
   logic [8:0] req_px;
   logic [8:0] req_py;
   logic [1:0] cur_dir;

   // Try order: straight, turn clockwise, turn counter-clockwise, reverse.
   function automatic logic [1:0] cand_dir(input logic [1:0] d, input logic [1:0] att);
      case (att)
         2'd0:    cand_dir = d;
         2'd1:    cand_dir = d + 2'd1;
         2'd2:    cand_dir = d + 2'd3;
         default: cand_dir = d + 2'd2;
      endcase
   endfunction

   function automatic logic [8:0] probe_x(input logic [8:0] x, input logic [1:0] d);
      logic [9:0] s;
      s = {1'b0, x} + 10'd8;
      case (d)
         2'd0:    probe_x = (s > {1'b0, MAX_X}) ? s[8:0] - MAX_X - 9'd1 : s[8:0];
         2'd2:    probe_x = (x == 9'd0) ? MAX_X : x - 9'd1;
         default: probe_x = x;
      endcase
   endfunction

   function automatic logic [8:0] probe_y(input logic [8:0] y, input logic [1:0] d);
      case (d)
         2'd1:    probe_y = y + 9'd8;
         2'd3:    probe_y = y - 9'd1;
         default: probe_y = y;
      endcase
   endfunction

   function automatic logic [8:0] step_x(input logic [8:0] x, input logic [1:0] d);
      case (d)
         2'd0:    step_x = (x == MAX_X) ? 9'd0 : x + 9'd1;
         2'd2:    step_x = (x == 9'd0) ? MAX_X : x - 9'd1;
         default: step_x = x;
      endcase
   endfunction

   function automatic logic [8:0] step_y(input logic [8:0] y, input logic [1:0] d);
      case (d)
         2'd1:    step_y = y + 9'd1;
         2'd3:    step_y = y - 9'd1;
         default: step_y = y;
      endcase
   endfunction

   // Probe for whichever ghost/attempt the FSM enters REQ with next.
   always_comb begin
      req_idx = idx_q;
      req_att = att_q + 2'd1;
      if (state_q == StIdle) begin
         req_idx = 2'd0;
         req_att = 2'd0;
      end else if (state_q == StNext) begin
         req_idx = idx_q + 2'd1;
         req_att = 2'd0;
      end
      req_dir = cand_dir(dir_q[req_idx], req_att);
      req_px  = probe_x(x_q[req_idx], req_dir);
      req_py  = probe_y(y_q[req_idx], req_dir);
      cur_dir = cand_dir(dir_q[idx_q], att_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         idx_q      <= 2'd0;
         att_q      <= 2'd0;
         mv_dir_q   <= 2'd0;
         wall_req_q <= 1'b0;
         wall_x_q   <= 9'd0;
         wall_y_q   <= 9'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overrun_q  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            x_q[i]   <= HOME_X + SPACING * 9'(i);
            y_q[i]   <= HOME_Y;
            dir_q[i] <= 2'd0;
         end
      end else begin
         done_q <= 1'b0;
         if (frame_start && busy_q) overrun_q <= 1'b1;
         case (state_q)
            StIdle: begin
               if (frame_start && enable) begin
                  state_q    <= StReq;
                  busy_q     <= 1'b1;
                  idx_q      <= 2'd0;
                  att_q      <= 2'd0;
                  wall_req_q <= 1'b1;
                  wall_x_q   <= req_px;
                  wall_y_q   <= req_py;
               end
            end
            StReq, StWait: begin
               if (wall_ack) begin
                  if (!wall_hit) begin
                     mv_dir_q   <= cur_dir;
                     wall_req_q <= 1'b0;
                     state_q    <= StMove;
                  end else if (att_q != 2'd3) begin
                     // Retry keeps wall_req high and presents the next candidate at once.
                     att_q    <= att_q + 2'd1;
                     wall_x_q <= req_px;
                     wall_y_q <= req_py;
                     state_q  <= StReq;
                  end else begin
                     wall_req_q <= 1'b0;
                     state_q    <= StNext;
                  end
               end else begin
                  state_q <= StWait;
               end
            end
            StMove: begin
               x_q[idx_q]   <= step_x(x_q[idx_q], mv_dir_q);
               y_q[idx_q]   <= step_y(y_q[idx_q], mv_dir_q);
               dir_q[idx_q] <= mv_dir_q;
               state_q      <= StNext;
            end
            StNext: begin
               if (idx_q != 2'd3) begin
                  idx_q      <= idx_q + 2'd1;
                  att_q      <= 2'd0;
                  wall_req_q <= 1'b1;
                  wall_x_q   <= req_px;
                  wall_y_q   <= req_py;
                  state_q    <= StReq;
               end else begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign wall_req = wall_req_q;
   assign wall_x   = wall_x_q;
   assign wall_y   = wall_y_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overrun  = overrun_q;
   assign x_red    = x_q[0];
   assign y_red    = y_q[0];
   assign x_pink   = x_q[1];
   assign y_pink   = y_q[1];
   assign x_blue   = x_q[2];
   assign y_blue   = y_q[2];
   assign x_yellow = x_q[3];
   assign y_yellow = y_q[3];

endmodule

// File: tb/tb_ghost_scheduler.sv
// Directed bench for ghost_scheduler: table of full passes against a wall map, plus
// hand sequences for stalled acks, overrun, enable gating and mid-pass reset.
module tb_ghost_scheduler;

   localparam logic [35:0] NW = {4{9'h1FF}};

   typedef struct packed {
      logic            w;
      logic            rf;
      logic [3:0][8:0] wx;
      logic [3:0][8:0] wy;
      logic [3:0][8:0] ex;
      logic [3:0][8:0] ey;
      logic [17:0]     fp;
      logic [17:0]     lp;
      logic [7:0]      np;
      logic [7:0]      lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst, en, fs_a, fs_w, auto_ack, man_ack, man_hit;

   logic            wr_a, ack_a, hit_a, wh_a, busy_a, done_a, ovr_a;
   logic [8:0]      wx_a, wy_a;
   logic [3:0][8:0] xa, ya;
   logic            wr_w, ack_w, hit_w, wh_w, busy_w, done_w, ovr_w;
   logic [8:0]      wx_w, wy_w;
   logic [3:0][8:0] xw, yw;

   logic [3:0][8:0] cwx, cwy;
   logic [17:0]     log_a[$];
   logic [17:0]     log_w[$];
   int tests = 0;
   int fails = 0;
   vec_t vecs[5];

   always #5 clk = ~clk;

   ghost_scheduler dut_a (
      .clk(clk), .rst(rst), .frame_start(fs_a), .enable(en),
      .wall_req(wr_a), .wall_x(wx_a), .wall_y(wy_a), .wall_ack(ack_a), .wall_hit(hit_a),
      .x_red(xa[0]), .y_red(ya[0]), .x_pink(xa[1]), .y_pink(ya[1]),
      .x_blue(xa[2]), .y_blue(ya[2]), .x_yellow(xa[3]), .y_yellow(ya[3]),
      .busy(busy_a), .done(done_a), .overrun(ovr_a)
   );

   ghost_scheduler #(.HOME_X(9'd223), .SPACING(9'd0)) dut_w (
      .clk(clk), .rst(rst), .frame_start(fs_w), .enable(en),
      .wall_req(wr_w), .wall_x(wx_w), .wall_y(wy_w), .wall_ack(ack_w), .wall_hit(hit_w),
      .x_red(xw[0]), .y_red(yw[0]), .x_pink(xw[1]), .y_pink(yw[1]),
      .x_blue(xw[2]), .y_blue(yw[2]), .x_yellow(xw[3]), .y_yellow(yw[3]),
      .busy(busy_w), .done(done_w), .overrun(ovr_w)
   );

   // Wall lookup model: zero-wait ack in auto mode, hand-driven otherwise.
   always_comb begin
      wh_a = 1'b0;
      wh_w = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (wx_a == cwx[i] && wy_a == cwy[i]) wh_a = 1'b1;
         if (wx_w == cwx[i] && wy_w == cwy[i]) wh_w = 1'b1;
      end
   end
   assign ack_a = auto_ack ? wr_a : man_ack;
   assign hit_a = auto_ack ? wh_a : man_hit;
   assign ack_w = auto_ack ? wr_w : 1'b0;
   assign hit_w = wh_w;

   always @(negedge clk) begin
      if (wr_a && ack_a) log_a.push_back({wx_a, wy_a});
      if (wr_w && ack_w) log_w.push_back({wx_w, wy_w});
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic run_pass(input bit w, output int lat);
      @(negedge clk);
      en = 1'b1;
      if (w) fs_w = 1'b1;
      else fs_a = 1'b1;
      @(negedge clk);
      fs_a = 1'b0;
      fs_w = 1'b0;
      lat = 1;
      while (!(w ? done_w : done_a) && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("busy_at_done", 32'(w ? busy_w : busy_a), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(w ? done_w : done_a), 32'd0);
   endtask

   function automatic vec_t mk(input logic w, input logic rf, input logic [35:0] wx,
                               input logic [35:0] wy, input logic [35:0] ex,
                               input logic [35:0] ey, input logic [17:0] fp,
                               input logic [17:0] lp, input logic [7:0] np,
                               input logic [7:0] lat);
      vec_t v;
      v.w = w; v.rf = rf; v.wx = wx; v.wy = wy; v.ex = ex; v.ey = ey;
      v.fp = fp; v.lp = lp; v.np = np; v.lat = lat;
      return v;
   endfunction

   initial begin
      int lat;
      int dn;
      logic act;
      logic [17:0] pk[4];

      rst = 1'b0; en = 1'b0; fs_a = 1'b0; fs_w = 1'b0;
      auto_ack = 1'b1; man_ack = 1'b0; man_hit = 1'b0;
      cwx = NW; cwy = NW;

      vecs[0] = mk(1'b0, 1'b1, NW, NW, {9'd145, 9'd129, 9'd113, 9'd97}, {4{9'd112}},
                   {9'd104, 9'd112}, {9'd152, 9'd112}, 8'd4, 8'd13);
      vecs[1] = mk(1'b0, 1'b1, {9'h1FF, 9'h1FF, 9'h1FF, 9'd104}, {9'h1FF, 9'h1FF, 9'h1FF, 9'd112},
                   {9'd145, 9'd129, 9'd113, 9'd96}, {9'd112, 9'd112, 9'd112, 9'd113},
                   {9'd104, 9'd112}, {9'd152, 9'd112}, 8'd5, 8'd14);
      vecs[2] = mk(1'b0, 1'b1, {9'd120, 9'd112, 9'd112, 9'd111}, {9'd112, 9'd120, 9'd111, 9'd112},
                   {9'd145, 9'd129, 9'd112, 9'd97}, {4{9'd112}},
                   {9'd104, 9'd112}, {9'd152, 9'd112}, 8'd7, 8'd15);
      vecs[3] = mk(1'b1, 1'b1, NW, NW, {4{9'd0}}, {4{9'd112}},
                   {9'd7, 9'd112}, {9'd7, 9'd112}, 8'd4, 8'd13);
      vecs[4] = mk(1'b1, 1'b0, {9'd8, 9'd0, 9'd0, 9'h1FF}, {9'd112, 9'd120, 9'd111, 9'h1FF},
                   {4{9'd223}}, {4{9'd112}}, {9'd8, 9'd112}, {9'd223, 9'd112}, 8'd16, 8'd25);

      // Reset state
      do_reset();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_x%0d", i), 32'(xa[i]), 32'd96 + 32'(i) * 32'd16);
         check($sformatf("rst_y%0d", i), 32'(ya[i]), 32'd112);
      end
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_req", 32'(wr_a), 32'd0);
      check("rst_ovr", 32'(ovr_a), 32'd0);

      // Table of whole passes
      for (int k = 0; k < 5; k++) begin
         if (vecs[k].rf) do_reset();
         cwx = vecs[k].wx;
         cwy = vecs[k].wy;
         log_a.delete();
         log_w.delete();
         run_pass(vecs[k].w, lat);
         check($sformatf("v%0d_latency", k), 32'(lat), 32'(vecs[k].lat));
         if (vecs[k].w) begin
            check($sformatf("v%0d_nprobe", k), 32'(log_w.size()), 32'(vecs[k].np));
            check($sformatf("v%0d_first", k), 32'(log_w[0]), 32'(vecs[k].fp));
            check($sformatf("v%0d_last", k), 32'(log_w[$]), 32'(vecs[k].lp));
         end else begin
            check($sformatf("v%0d_nprobe", k), 32'(log_a.size()), 32'(vecs[k].np));
            check($sformatf("v%0d_first", k), 32'(log_a[0]), 32'(vecs[k].fp));
            check($sformatf("v%0d_last", k), 32'(log_a[$]), 32'(vecs[k].lp));
         end
         for (int i = 0; i < 4; i++) begin
            check($sformatf("v%0d_x%0d", k, i), 32'(vecs[k].w ? xw[i] : xa[i]),
                  32'(vecs[k].ex[i]));
            check($sformatf("v%0d_y%0d", k, i), 32'(vecs[k].w ? yw[i] : ya[i]),
                  32'(vecs[k].ey[i]));
         end
      end

      // Red turns down, then keeps heading down on the next pass
      do_reset();
      cwx = {9'h1FF, 9'h1FF, 9'h1FF, 9'd104};
      cwy = {9'h1FF, 9'h1FF, 9'h1FF, 9'd112};
      log_a.delete();
      run_pass(1'b0, lat);
      check("red_probe0", 32'(log_a[0]), 32'({9'd104, 9'd112}));
      check("red_probe1", 32'(log_a[1]), 32'({9'd96, 9'd120}));
      cwx = NW; cwy = NW;
      log_a.delete();
      run_pass(1'b0, lat);
      check("red_dir_down_probe", 32'(log_a[0]), 32'({9'd96, 9'd121}));
      check("red_x_after2", 32'(xa[0]), 32'd96);
      check("red_y_after2", 32'(ya[0]), 32'd114);

      // Pink fully boxed in: probe order right, down, up, left; dir stays right
      do_reset();
      cwx = {9'd120, 9'd112, 9'd112, 9'd111};
      cwy = {9'd112, 9'd120, 9'd111, 9'd112};
      pk[0] = {9'd120, 9'd112}; pk[1] = {9'd112, 9'd120};
      pk[2] = {9'd112, 9'd111}; pk[3] = {9'd111, 9'd112};
      log_a.delete();
      run_pass(1'b0, lat);
      for (int i = 0; i < 4; i++) check($sformatf("pink_probe%0d", i), 32'(log_a[i + 1]),
                                         32'(pk[i]));
      cwx = NW; cwy = NW;
      log_a.delete();
      run_pass(1'b0, lat);
      check("pink_dir_kept", 32'(log_a[1]), 32'({9'd120, 9'd112}));
      check("pink_x_after2", 32'(xa[1]), 32'd113);

      // Stalled ack: request held stable, overrun on a second frame_start
      do_reset();
      auto_ack = 1'b0;
      man_ack = 1'b0;
      @(negedge clk);
      en = 1'b1;
      fs_a = 1'b1;
      @(negedge clk);
      fs_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("stall_req%0d", i), 32'({wr_a, wx_a, wy_a}),
               32'({1'b1, 9'd104, 9'd112}));
         fs_a = (i == 3);
         @(negedge clk);
      end
      fs_a = 1'b0;
      check("overrun_set", 32'(ovr_a), 32'd1);
      man_ack = 1'b1;
      man_hit = 1'b0;
      @(negedge clk);
      man_ack = 1'b0;
      check("req_drop_after_ack", 32'(wr_a), 32'd0);
      auto_ack = 1'b1;
      dn = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done_a) dn++;
      end
      check("single_pass_done", 32'(dn), 32'd1);
      check("stall_red_x", 32'(xa[0]), 32'd97);
      check("stall_yel_x", 32'(xa[3]), 32'd145);
      check("overrun_sticky", 32'(ovr_a), 32'd1);

      // enable low blocks frame_start; acks while idle are ignored
      en = 1'b0;
      fs_a = 1'b1;
      @(negedge clk);
      fs_a = 1'b0;
      act = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (busy_a || wr_a) act = 1'b1;
         @(negedge clk);
      end
      check("enable_low_idle", 32'(act), 32'd0);
      auto_ack = 1'b0;
      man_ack = 1'b1;
      man_hit = 1'b0;
      repeat (3) @(negedge clk);
      man_ack = 1'b0;
      check("idle_ack_red_x", 32'(xa[0]), 32'd97);
      check("idle_ack_busy", 32'(busy_a), 32'd0);
      en = 1'b1;

      // Reset while pink waits for its ack
      do_reset();
      @(negedge clk);
      fs_a = 1'b1;
      @(negedge clk);
      fs_a = 1'b0;
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      @(negedge clk);
      check("mid_red_moved", 32'(xa[0]), 32'd97);
      repeat (2) @(negedge clk);
      check("mid_pink_wait", 32'({wr_a, wx_a}), 32'({1'b1, 9'd120}));
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("mid_rst_x%0d", i), 32'(xa[i]), 32'd96 + 32'(i) * 32'd16);
         check($sformatf("mid_rst_y%0d", i), 32'(ya[i]), 32'd112);
      end
      check("mid_rst_req", 32'(wr_a), 32'd0);
      check("mid_rst_busy", 32'(busy_a), 32'd0);
      check("mid_rst_ovr", 32'(ovr_a), 32'd0);
      man_ack = 1'b1;
      repeat (3) @(negedge clk);
      man_ack = 1'b0;
      check("late_ack_red_x", 32'(xa[0]), 32'd96);
      check("late_ack_pink_x", 32'(xa[1]), 32'd112);
      check("late_ack_busy", 32'(busy_a), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
